// File: rtl/ram_arbiter_pkg.sv
// Shared definitions for the ram_arbiter front end: address width helper,
// grant encoding and stall counter limit.
package ram_arbiter_pkg;

  typedef enum logic [1:0] {
    GRANT_NONE = 2'd0,
    GRANT_A    = 2'd1,
    GRANT_B    = 2'd2
  } grant_t;

  localparam logic [15:0] STALL_MAX = 16'hFFFF;

  function automatic int addr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: bit 0 = port A, bit 1 = port B.
// On a conflict the most recently granted port loses; history moves only on a grant.
module rr_arb2
  import ram_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  output logic [1:0] grant
);

  grant_t last;

  always_comb begin
    grant = '0;
    if (!rst) begin
      unique case (req)
        2'b01:   grant = 2'b01;
        2'b10:   grant = 2'b10;
        2'b11:   grant = (last == GRANT_A) ? 2'b10 : 2'b01;
        default: grant = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last <= GRANT_A;
    end else if (grant[0]) begin
      last <= GRANT_A;
    end else if (grant[1]) begin
      last <= GRANT_B;
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// Two-requester front end for a single-port, one-cycle-latency RAM:
// arbitration, RAM drive, read-response routing with hold, stall counter.
module ram_arbiter
  import ram_arbiter_pkg::*;
#(
  parameter  int SIZE  = 16,
  parameter  int DEPTH = 256,
  localparam int AW    = addr_width(DEPTH)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            a_req,
  input  logic [AW-1:0]   a_addr,
  output logic            a_ack,
  output logic            a_rvalid,
  output logic [SIZE-1:0] a_rdata,
  input  logic            b_req,
  input  logic            b_we,
  input  logic [AW-1:0]   b_addr,
  input  logic [SIZE-1:0] b_wdata,
  output logic            b_ack,
  output logic            b_rvalid,
  output logic [SIZE-1:0] b_rdata,
  output logic [AW-1:0]   ram_address,
  output logic [SIZE-1:0] ram_write_data,
  output logic            ram_write_en,
  input  logic [SIZE-1:0] ram_read_data,
  output logic [15:0]     stall_count
);

  logic [1:0]      grant;
  logic            pend_a, pend_b;
  logic [SIZE-1:0] hold_a, hold_b;

  rr_arb2 u_arb (
    .clk   (clk),
    .rst   (rst),
    .req   ({b_req, a_req}),
    .grant (grant)
  );

  assign a_ack = grant[0];
  assign b_ack = grant[1];

  assign ram_address    = b_ack ? b_addr : a_addr;
  assign ram_write_en   = b_ack & b_we;
  assign ram_write_data = b_wdata;

  // Gating with rst drops a response whose read was granted just before reset.
  assign a_rvalid = pend_a & ~rst;
  assign b_rvalid = pend_b & ~rst;

  assign a_rdata = a_rvalid ? ram_read_data : hold_a;
  assign b_rdata = b_rvalid ? ram_read_data : hold_b;

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_a      <= 1'b0;
      pend_b      <= 1'b0;
      hold_a      <= '0;
      hold_b      <= '0;
      stall_count <= '0;
    end else begin
      pend_a <= a_ack;
      pend_b <= b_ack & ~b_we;
      if (a_rvalid) hold_a <= ram_read_data;
      if (b_rvalid) hold_b <= ram_read_data;
      if (((a_req & ~a_ack) | (b_req & ~b_ack)) && (stall_count != STALL_MAX))
        stall_count <= stall_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Scoreboard bench for ram_arbiter: a behavioural RAM, a reference model of the
// arbitration/memory rules, and a monitor checking read responses per port.
module tb_ram_arbiter;

  localparam int SIZE  = 16;
  localparam int DEPTH = 256;
  localparam int AW    = 8;

  typedef struct {
    int            cyc;
    logic [SIZE-1:0] data;
  } resp_t;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            a_req = 1'b0, b_req = 1'b0, b_we = 1'b0;
  logic [AW-1:0]   a_addr = '0, b_addr = '0;
  logic [SIZE-1:0] b_wdata = '0;
  logic            a_ack, a_rvalid, b_ack, b_rvalid, ram_write_en;
  logic [SIZE-1:0] a_rdata, b_rdata, ram_write_data, ram_read_data;
  logic [AW-1:0]   ram_address;
  logic [15:0]     stall_count;

  logic [SIZE-1:0] mem     [DEPTH];
  logic [SIZE-1:0] ref_mem [DEPTH];
  resp_t           exp_a[$], exp_b[$];
  int              total = 0, bad = 0, cyc = 0;
  int              model_stall = 0;
  bit              last_b = 1'b0;
  logic [SIZE-1:0] hold_a = '0, hold_b = '0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ram_arbiter #(.SIZE(SIZE), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .a_req(a_req), .a_addr(a_addr), .a_ack(a_ack), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata), .b_ack(b_ack),
    .b_rvalid(b_rvalid), .b_rdata(b_rdata),
    .ram_address(ram_address), .ram_write_data(ram_write_data), .ram_write_en(ram_write_en),
    .ram_read_data(ram_read_data), .stall_count(stall_count)
  );

  // Single-port synchronous RAM with one-cycle read latency.
  always @(posedge clk) begin
    if (ram_write_en) mem[ram_address] <= ram_write_data;
    ram_read_data <= mem[ram_address];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Apply one cycle of stimulus, predict grants from the round-robin rule and
  // update the reference memory and response queues.
  task automatic cycle(input logic r, input logic ar, input logic [AW-1:0] aa,
                       input logic br, input logic bw, input logic [AW-1:0] ba,
                       input logic [SIZE-1:0] bd, output logic ga, output logic gb);
    logic ea, eb;
    @(posedge clk);
    #1;
    rst = r; a_req = ar; a_addr = aa; b_req = br; b_we = bw; b_addr = ba; b_wdata = bd;
    @(negedge clk);
    if (r)             begin ea = 1'b0; eb = 1'b0; end
    else if (ar && br) begin eb = !last_b; ea = last_b; end
    else               begin ea = ar; eb = br; end
    check("a_ack", a_ack, ea);
    check("b_ack", b_ack, eb);
    check("ram_write_en", ram_write_en, eb && bw);
    check("ram_write_data", ram_write_data, bd);
    if (!r) check("ram_address", ram_address, eb ? ba : aa);
    if (r) begin
      model_stall = 0;
      last_b = 1'b0;
      exp_a.delete();
      exp_b.delete();
    end else begin
      check("stall_count", stall_count, model_stall);
      if ((ar && !ea) || (br && !eb))
        model_stall = (model_stall >= 65535) ? 65535 : model_stall + 1;
      if (ea) begin
        last_b = 1'b0;
        exp_a.push_back('{cyc + 1, ref_mem[aa]});
      end
      if (eb) begin
        last_b = 1'b1;
        if (bw) ref_mem[ba] = bd;
        else    exp_b.push_back('{cyc + 1, ref_mem[ba]});
      end
    end
    ga = ea; gb = eb;
  endtask

  // Monitor: a response is due exactly in the cycle after its grant.
  always @(negedge clk) begin
    bit ev_a, ev_b;
    if (rst) begin
      check("a_rvalid_in_rst", a_rvalid, 1'b0);
      check("b_rvalid_in_rst", b_rvalid, 1'b0);
      hold_a = '0;
      hold_b = '0;
    end else begin
      ev_a = (exp_a.size() > 0) && (exp_a[0].cyc == cyc);
      ev_b = (exp_b.size() > 0) && (exp_b[0].cyc == cyc);
      check("a_rvalid", a_rvalid, ev_a);
      check("b_rvalid", b_rvalid, ev_b);
      if (ev_a) hold_a = exp_a.pop_front().data;
      if (ev_b) hold_b = exp_b.pop_front().data;
      check("a_rdata", a_rdata, hold_a);
      check("b_rdata", b_rdata, hold_b);
    end
  end

  initial begin
    logic ga, gb;
    logic aq, bq, bw;
    logic [AW-1:0] aa, ba;
    logic [SIZE-1:0] bd, v;

    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
    cycle(1, 0, '0, 0, 0, '0, '0, ga, gb);
    cycle(1, 0, '0, 0, 0, '0, '0, ga, gb);

    // Preload every RAM word through port B writes.
    for (int i = 0; i < DEPTH; i++) begin
      v = SIZE'($urandom);
      if (i == 'h10) v = 16'h1234;
      if (i == 'h01) v = 16'hAAAA;
      if (i == 'h02) v = 16'h5555;
      cycle(0, 0, '0, 1, 1, AW'(i), v, ga, gb);
    end
    cycle(0, 0, '0, 0, 0, '0, '0, ga, gb);

    // Basic read, then idle so the held value is observed.
    cycle(0, 1, 8'h10, 0, 0, '0, '0, ga, gb);
    for (int i = 0; i < 3; i++) cycle(0, 0, '0, 0, 0, '0, '0, ga, gb);
    check("basic_read_hold", a_rdata, 16'h1234);

    // Write then read the same address on B.
    cycle(0, 0, '0, 1, 1, 8'h20, 16'hBEEF, ga, gb);
    cycle(0, 0, '0, 1, 0, 8'h20, '0, ga, gb);
    for (int i = 0; i < 2; i++) cycle(0, 0, '0, 0, 0, '0, '0, ga, gb);
    check("write_read", b_rdata, 16'hBEEF);

    // Data isolation: B's response must not disturb A's held data.
    cycle(0, 1, 8'h01, 0, 0, '0, '0, ga, gb);
    cycle(0, 0, '0, 1, 0, 8'h02, '0, ga, gb);
    cycle(0, 0, '0, 0, 0, '0, '0, ga, gb);
    check("isolation_a", a_rdata, 16'hAAAA);
    check("isolation_b", b_rdata, 16'h5555);

    // Reset mid-read, then a conflict after reset.
    cycle(0, 1, 8'h10, 0, 0, '0, '0, ga, gb);
    cycle(1, 0, '0, 0, 0, '0, '0, ga, gb);
    cycle(1, 0, '0, 0, 0, '0, '0, ga, gb);
    cycle(0, 0, '0, 0, 0, '0, '0, ga, gb);
    check("post_reset_stall", stall_count, 16'd0);
    check("post_reset_a_rdata", a_rdata, 16'd0);
    for (int i = 0; i < 6; i++)
      cycle(0, 1, AW'(i + 1), 1, 0, AW'(i + 100), '0, ga, gb);
    cycle(0, 0, '0, 0, 0, '0, '0, ga, gb);
    check("conflict_stall6", stall_count, 16'd6);

    // Randomized traffic; requests are held until the modelled ack.
    aq = 0; bq = 0; bw = 0; aa = '0; ba = '0; bd = '0;
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) begin
        cycle(1, 0, '0, 0, 0, '0, '0, ga, gb);
        aq = 0; bq = 0;
        continue;
      end
      cycle(0, aq, aa, bq, bw, ba, bd, ga, gb);
      if (!aq || ga) begin
        aq = ($urandom_range(0, 3) != 0);
        aa = AW'($urandom);
      end
      if (!bq || gb) begin
        bq = ($urandom_range(0, 3) != 0);
        bw = ($urandom_range(0, 2) == 0);
        ba = AW'($urandom);
        bd = SIZE'($urandom);
      end
    end

    // Saturation: continuous conflict long enough to pin the counter.
    for (int i = 0; i < 65600; i++)
      cycle(0, 1, AW'($urandom), 1, 0, AW'($urandom), '0, ga, gb);
    cycle(0, 0, '0, 0, 0, '0, '0, ga, gb);
    check("stall_saturated", stall_count, 16'hFFFF);
    cycle(0, 0, '0, 0, 0, '0, '0, ga, gb);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
